// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared encodings and sizing helper for the pooling window unit
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } pool_state_e;

  // Smallest r with 2**r >= value; used for counter and accumulator sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_reduce.sv
// rtl/pool_reduce.sv - combinational next-value unit: running sum, running max, saturated average
module pool_reduce #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 11,
  parameter int SHIFT  = 3
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] max_i,
  input  logic [DATA_W-1:0] in_data,
  input  logic              first_i,
  output logic [ACC_W-1:0]  acc_new,
  output logic [DATA_W-1:0] max_new,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_sat
);

  logic [ACC_W-1:0] shifted;

  always_comb begin
    acc_new  = first_i ? ACC_W'(in_data) : acc_i + ACC_W'(in_data);
    max_new  = (first_i || (in_data > max_i)) ? in_data : max_i;
    shifted  = acc_new >> SHIFT;
    // Any bit above the result width means the average does not fit.
    avg_sat  = |shifted[ACC_W-1:DATA_W];
    avg_data = avg_sat ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/pool_window_unit.sv
// rtl/pool_window_unit.sv - streaming window pooling engine (shift-average or max per window)
module pool_window_unit
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 6,
  parameter int SHIFT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sat,
  output logic [clog2(WIN+1)-1:0]   out_count
);

  localparam int CNT_W = clog2(WIN + 1);
  localparam int ACC_W = DATA_W + CNT_W;

  pool_state_e       state_q, state_d;
  pool_mode_e        mode_q, mode_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;

  logic              first;
  logic              accept;
  pool_mode_e        cur_mode;
  logic [CNT_W-1:0]  cnt_new;
  logic [ACC_W-1:0]  acc_new;
  logic [DATA_W-1:0] max_new;
  logic [DATA_W-1:0] avg_data;
  logic              avg_sat;

  assign first  = (cnt_q == '0);
  assign accept = in_valid && (state_q == ST_ACCUM);

  pool_reduce #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_reduce (
    .acc_i    (acc_q),
    .max_i    (max_q),
    .in_data  (in_data),
    .first_i  (first),
    .acc_new  (acc_new),
    .max_new  (max_new),
    .avg_data (avg_data),
    .avg_sat  (avg_sat)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    // Mode is only honoured on the first sample; later changes are ignored.
    cur_mode    = first ? pool_mode_e'(mode) : mode_q;
    cnt_new     = first ? CNT_W'(1) : cnt_q + CNT_W'(1);

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          mode_d = cur_mode;
          acc_d  = acc_new;
          max_d  = max_new;
          cnt_d  = cnt_new;
          if ((cnt_new == CNT_W'(WIN)) || in_last) begin
            out_data_d  = (cur_mode == POOL_MAX) ? max_new : avg_data;
            out_sat_d   = (cur_mode == POOL_MAX) ? 1'b0 : avg_sat;
            out_count_d = cnt_new;
            acc_d       = '0;
            max_d       = '0;
            cnt_d       = '0;
            state_d     = ST_OUTPUT;
          end
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      mode_q      <= POOL_AVG;
      acc_q       <= '0;
      max_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUTPUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: doc/pool_window_unit.md
Name: pool_window_unit

Overview:
- Streaming pooling engine for the pooling BRAM datapath; successor to the fixed 6-input combinational averager.
- Accepts one DATA_W-bit unsigned sample per handshake and accumulates a window of up to WIN samples.
- Emits one pooled result per window: shift-average or maximum, selectable per window.
- Sits between the BRAM read port and the result write-back logic; valid/ready on both sides.

Parameters:
- DATA_W, 8, sample and result width (unsigned).
- WIN, 6, nominal window length in samples (>=1).
- SHIFT, 3, right-shift applied to the sum in average mode (0..ACC_W-1).
- ACC_W, DATA_W+$clog2(WIN+1), accumulator width; derived, not overridden.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = average (sum>>SHIFT), 1 = max; sampled with first sample of each window.
- in_valid  in  1  sample valid.
- in_ready  out  1  unit can accept a sample.
- in_data  in  DATA_W  sample value.
- in_last  in  1  ends the window early with this sample.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  pooled result.
- out_sat  out  1  average result was clipped to all-ones.
- out_count  out  $clog2(WIN+1)  number of samples in the emitted window.

Behaviour:
- Reset (rst=1 at clk edge): state=ACCUM, acc=0, max=0, cnt=0, in_ready=1, out_valid=0, out_data=0, out_sat=0, out_count=0. Reset mid-window discards partial window; reset while out_valid=1 drops the held result.
- Accept = in_valid & in_ready; emit = out_valid & out_ready.
- State ACCUM: in_ready=1, out_valid=0.
  - On accept with cnt==0: latch mode; acc=in_data; max=in_data; cnt=1.
  - On accept with cnt>0: acc+=in_data; max=max(max,in_data); cnt+=1.
  - Window closes on the accept where new cnt==WIN or in_last=1. The result registers are loaded on that same edge, state goes to OUTPUT, and the accumulators clear.
- Result computation, on the closing edge using the updated acc/max:
  - avg: q = acc_new >> SHIFT. If q > 2^DATA_W-1, out_data = all-ones and out_sat=1; else out_data = q[DATA_W-1:0] and out_sat=0.
  - max: out_data = max_new, out_sat=0.
  - out_count = cnt_new.
- State OUTPUT: out_valid=1, in_ready=0. out_data, out_sat and out_count are held stable until emit. On emit, go to ACCUM; the next accept is possible on the following cycle.
- Latency: result is valid in the cycle after the closing accept.
- Throughput: best case one window per WIN+1 cycles.
- Mode changes mid-window are ignored.
- in_last on the WIN-th sample is the same as the normal close (no extra window).
- in_last with cnt==0 closes a 1-sample window.
- in_data is ignored when in_valid=0.
- The accumulator never overflows, because ACC_W covers WIN*(2^DATA_W-1).

Decomposition:
- Shared package `pool_pkg`:
  - mode encodings POOL_AVG=0, POOL_MAX=1;
  - state encodings ST_ACCUM, ST_OUTPUT;
  - the clog2 helper function.
- One sub-module, `pool_reduce`: a combinational next-value unit. It takes acc, max, in_data and first-sample flag, and returns acc_new, max_new and the saturated average.
- The FSM, counters and output registers stay in `pool_window_unit`.

Test Plan (defaults unless stated):
- Avg full window: mode=0; samples 10,20,30,40,50,60, out_ready=1 -> one result, out_data=26, out_sat=0, out_count=6. out_valid rises exactly 1 cycle after the 6th accept.
- Max full window: mode=1; samples 3,200,7,199,0,200 -> out_data=200, out_count=6. Then mode=1 all-255 window -> 255.
- Early close: mode=0; samples 100,100,100 with in_last on the 3rd -> out_data=37, out_count=3. The next window starts fresh: 6x8 -> 6.
- Backpressure: full avg window of all 255 with out_ready=0 for 5 cycles -> out_data=191 stable, in_ready=0 throughout, in_valid pulses ignored. Emit on the first cycle out_ready=1; in_ready=1 the next cycle.
- Saturation: parameters WIN=2, SHIFT=0; samples 255,255 -> out_data=255, out_sat=1, out_count=2. Samples 100,50 -> 150, out_sat=0.
- Reset/mode: rst=1 after 3 accepted samples -> all outputs 0. Then a new window with mode toggled mid-window (mode=1 at the first sample, 0 later) -> max result used.
